// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared types and widths for the FIR sequencer
//
// Purpose: FSM state encoding and datapath widths used by fir_seq_ctrl,
//          its slot divider and the bench datapath model.
// Ports:   none (package).
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int COEF_W    = 8;
    localparam int SMP_W     = 8;
    localparam int Y_W       = 18;
    localparam int COEF_BITS = 32;

endpackage

// File: rtl/fir_ctrl_slot_div.sv
// rtl/fir_ctrl_slot_div.sv - DATA_DIV sample-slot counter
//
// Purpose: counts 0..DATA_DIV-1 and wraps while enabled; a synchronous
//          clear holds it at 0 so the first enabled cycle is slot start.
// Ports:
//   clk_i   in  1  clock
//   rst_ni  in  1  asynchronous active-low reset
//   clr_i   in  1  synchronous clear (dominates enable)
//   en_i    in  1  count enable
//   zero_o  out 1  counter is at 0 (start of a sample slot)
module fir_ctrl_slot_div #(
    parameter int DATA_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic zero_o
);

    logic [3:0] div_q;
    logic [3:0] div_d;

    always_comb begin
        div_d = div_q;
        if (clr_i) begin
            div_d = 4'd0;
        end else if (en_i) begin
            div_d = (div_q == 4'(DATA_DIV - 1)) ? 4'd0 : div_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= 4'd0;
        end else begin
            div_q <= div_d;
        end
    end

    assign zero_o = (div_q == 4'd0);

endmodule

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - coefficient loader and sample pacer for the 4-tap FIR core
//
// Purpose: accepts a 32-bit coefficient word and shifts it MSB first onto the
//          core's serial coefficient chain (32 LOAD cycles), then paces samples
//          to one per DATA_DIV cycles, pulses data_clk_en per sample and
//          flags y_valid PIPE_LAT cycles after each sample that completes the
//          tap fill. Optional macro FIR_CTRL_PERF_EN adds smp_count/drop_count.
// Ports:
//   ph1          in  1   clock
//   reset        in  1   asynchronous active-low reset
//   cfg_valid    in  1   coefficient word valid
//   cfg_ready    out 1   coefficient word can be accepted
//   cfg_coef     in  32  {c3,c2,c1,c0}
//   smp_valid    in  1   sample valid
//   smp_ready    out 1   sample accepted this cycle (combinational)
//   smp_data     in  8   sample
//   a            out 8   registered sample to the datapath
//   data_clk_en  out 1   one-cycle datapath data clock enable
//   shift_clk_en out 1   coefficient chain shift enable
//   shift_in     out 1   coefficient chain serial bit
//   y_valid      out 1   one-cycle pulse, datapath y valid
//   busy         out 1   coefficient load in progress
//   smp_count    out 16  accepted samples, saturating (FIR_CTRL_PERF_EN only)
//   drop_count   out 16  empty RUN slots, saturating (FIR_CTRL_PERF_EN only)
module fir_seq_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_DIV = 4,
    parameter int TAPS     = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic                 ph1,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [COEF_BITS-1:0] cfg_coef,
    input  logic                 smp_valid,
    output logic                 smp_ready,
    input  logic [SMP_W-1:0]     smp_data,
    output logic [SMP_W-1:0]     a,
    output logic                 data_clk_en,
    output logic                 shift_clk_en,
    output logic                 shift_in,
    output logic                 y_valid,
    output logic                 busy
`ifdef FIR_CTRL_PERF_EN
    ,
    output logic [15:0]          smp_count,
    output logic [15:0]          drop_count
`endif
);

    localparam int FW = $clog2(TAPS + 1);
    localparam int BW = $clog2(COEF_BITS);

    state_t                 state_q;
    logic [COEF_BITS-1:0]   shreg_q;
    logic [BW-1:0]          bitcnt_q;
    logic [SMP_W-1:0]       a_q;
    logic                   dce_q;
    logic                   sce_q;
    logic                   busy_q;
    logic [FW-1:0]          fill_q;
    // tag_q travels alongside data_clk_en; pipe_q carries it to y_valid.
    logic                   tag_q;
    logic [PIPE_LAT-1:0]    pipe_q;

    logic                   slot_zero;
    logic                   pending;
    logic                   cfg_hs;
    logic                   smp_hs;
    logic [FW-1:0]          fill_next;

    fir_ctrl_slot_div #(
        .DATA_DIV (DATA_DIV)
    ) u_slot_div (
        .clk_i  (ph1),
        .rst_ni (reset),
        .clr_i  (state_q != RUN),
        .en_i   (1'b1),
        .zero_o (slot_zero)
    );

    assign pending = tag_q | (|pipe_q);

    // Gated by reset so both ready outputs read 0 while reset is held.
    assign cfg_ready = reset & ((state_q == IDLE) | ((state_q == RUN) & ~pending));
    // A coefficient request takes the slot even if it cannot be accepted yet.
    assign smp_ready = reset & (state_q == RUN) & slot_zero & ~cfg_valid;

    assign cfg_hs = cfg_valid & cfg_ready;
    assign smp_hs = smp_valid & smp_ready;

    assign fill_next = (fill_q == FW'(TAPS)) ? fill_q : fill_q + FW'(1);

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            a_q      <= '0;
            dce_q    <= 1'b0;
            sce_q    <= 1'b0;
            busy_q   <= 1'b0;
            fill_q   <= '0;
            tag_q    <= 1'b0;
            pipe_q   <= '0;
        end else begin
            dce_q     <= 1'b0;
            tag_q     <= 1'b0;
            pipe_q[0] <= tag_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end

            case (state_q)
                IDLE: begin
                    if (cfg_hs) begin
                        state_q  <= LOAD;
                        shreg_q  <= cfg_coef;
                        bitcnt_q <= '0;
                        sce_q    <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                LOAD: begin
                    // shift_in is shreg_q[31], so bit 31-k is on the wire in cycle k.
                    shreg_q <= {shreg_q[COEF_BITS-2:0], 1'b0};
                    if (bitcnt_q == BW'(COEF_BITS - 1)) begin
                        state_q <= RUN;
                        sce_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        fill_q  <= '0;
                    end else begin
                        bitcnt_q <= bitcnt_q + BW'(1);
                    end
                end
                RUN: begin
                    if (cfg_hs) begin
                        // New coefficients invalidate the taps already filled.
                        state_q  <= LOAD;
                        shreg_q  <= cfg_coef;
                        bitcnt_q <= '0;
                        sce_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        fill_q   <= '0;
                    end else if (smp_hs) begin
                        a_q    <= smp_data;
                        dce_q  <= 1'b1;
                        fill_q <= fill_next;
                        tag_q  <= (fill_next == FW'(TAPS));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a            = a_q;
    assign data_clk_en  = dce_q;
    assign shift_clk_en = sce_q;
    assign shift_in     = shreg_q[COEF_BITS-1];
    assign y_valid      = pipe_q[PIPE_LAT-1];
    assign busy         = busy_q;

`ifdef FIR_CTRL_PERF_EN
    logic [15:0] smp_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            smp_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (cfg_hs) begin
                smp_cnt_q <= '0;
            end else if (smp_hs && (smp_cnt_q != 16'hFFFF)) begin
                smp_cnt_q <= smp_cnt_q + 16'd1;
            end
            if ((state_q == RUN) && slot_zero && !smp_valid && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign smp_count  = smp_cnt_q;
    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - directed self-checking bench for fir_seq_ctrl
module tb_fir_seq_ctrl;
    import fir_ctrl_pkg::*;

    logic        ph1 = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_coef = 32'd0;
    logic        smp_valid = 1'b0;
    logic [7:0]  smp_data = 8'd0;
    logic        cfg_ready, smp_ready, data_clk_en, shift_clk_en, shift_in, y_valid, busy;
    logic [7:0]  a;
`ifdef FIR_CTRL_PERF_EN
    logic [15:0] smp_count, drop_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 ph1 = ~ph1;

    fir_seq_ctrl #(.DATA_DIV(4), .TAPS(4), .PIPE_LAT(2)) dut (
        .ph1          (ph1),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_coef     (cfg_coef),
        .smp_valid    (smp_valid),
        .smp_ready    (smp_ready),
        .smp_data     (smp_data),
        .a            (a),
        .data_clk_en  (data_clk_en),
        .shift_clk_en (shift_clk_en),
        .shift_in     (shift_in),
        .y_valid      (y_valid),
        .busy         (busy)
`ifdef FIR_CTRL_PERF_EN
        ,
        .smp_count    (smp_count),
        .drop_count   (drop_count)
`endif
    );

    // Behavioural FIR core: serial coefficient chain plus 4-deep sample history.
    logic [31:0]    chain = 32'd0;
    logic [31:0]    hist  = 32'd0;
    logic [Y_W-1:0] y_dp;

    always @(posedge ph1) begin
        if (shift_clk_en) chain <= {chain[30:0], shift_in};
        if (data_clk_en)  hist  <= {hist[23:0], a};
    end

    always_comb begin
        y_dp = Y_W'(chain[7:0])   * Y_W'(hist[7:0])
             + Y_W'(chain[15:8])  * Y_W'(hist[15:8])
             + Y_W'(chain[23:16]) * Y_W'(hist[23:16])
             + Y_W'(chain[31:24]) * Y_W'(hist[31:24]);
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge ph1);
        #1;
        checks++;
        if ({cfg_ready, smp_ready, data_clk_en, shift_clk_en, shift_in, y_valid, busy, a} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {cfg_ready, smp_ready, data_clk_en, shift_clk_en, shift_in, y_valid, busy, a});
        end
        @(negedge ph1);
        reset = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1 || smp_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got cfg_ready=%b smp_ready=%b busy=%b required 1 0 0",
                     cfg_ready, smp_ready, busy);
        end
    endtask

    // Caller has just presented the handshake; the next 32 cycles are LOAD.
    task automatic test_load(input logic [31:0] coef);
        logic [31:0] got;
        got = 32'd0;
        for (int k = 0; k < 32; k++) begin
            @(negedge ph1);
            cfg_valid = 1'b0;
            smp_valid = 1'b0;
            #1;
            checks++;
            if (shift_clk_en !== 1'b1 || busy !== 1'b1 || cfg_ready !== 1'b0 ||
                smp_ready !== 1'b0 || data_clk_en !== 1'b0) begin
                errors++;
                $display("FAIL load_cycle_%0d: got sce=%b busy=%b cfg_rdy=%b smp_rdy=%b dce=%b required 1 1 0 0 0",
                         k, shift_clk_en, busy, cfg_ready, smp_ready, data_clk_en);
            end
            got = {got[30:0], shift_in};
        end
        checks++;
        if (got !== coef) begin
            errors++;
            $display("FAIL shift_stream: got %h required %h", got, coef);
        end
    endtask

    task automatic test_coef();
        @(negedge ph1);
        cfg_coef  = 32'h04030201;
        cfg_valid = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1 || shift_clk_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_cfg_ready: got cfg_ready=%b sce=%b required 1 0", cfg_ready, shift_clk_en);
        end
        test_load(32'h04030201);
    endtask

    // Starts on the first RUN cycle (r=0) and ends on r=16.
    task automatic test_fill(input logic [Y_W-1:0] y_exp);
        int acc;
        acc = 0;
        for (int r = 0; r <= 16; r++) begin
            @(negedge ph1);
            cfg_valid = 1'b0;
            smp_valid = (acc < 4);
            smp_data  = 8'(acc + 1);
            #1;
            checks++;
            if (smp_ready !== (r % 4 == 0)) begin
                errors++;
                $display("FAIL fill_smp_ready r=%0d: got %b required %b", r, smp_ready, (r % 4 == 0));
            end
            checks++;
            if (data_clk_en !== (r % 4 == 1 && r <= 13) || shift_clk_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL fill_enables r=%0d: got dce=%b sce=%b busy=%b required dce=%b sce=0 busy=0",
                         r, data_clk_en, shift_clk_en, busy, (r % 4 == 1 && r <= 13));
            end
            if (data_clk_en === 1'b1) begin
                checks++;
                if (a !== 8'((r - 1) / 4 + 1)) begin
                    errors++;
                    $display("FAIL fill_a r=%0d: got %0d required %0d", r, a, (r - 1) / 4 + 1);
                end
            end
            checks++;
            if (y_valid !== (r == 15)) begin
                errors++;
                $display("FAIL fill_y_valid r=%0d: got %b required %b", r, y_valid, (r == 15));
            end
            if (r == 15) begin
                checks++;
                if (y_dp !== y_exp) begin
                    errors++;
                    $display("FAIL fill_y: got %0d required %0d", y_dp, y_exp);
                end
            end
            checks++;
            if (cfg_ready !== !(r >= 13 && r <= 15)) begin
                errors++;
                $display("FAIL fill_cfg_ready r=%0d: got %b required %b", r, cfg_ready, !(r >= 13 && r <= 15));
            end
            if (smp_valid && smp_ready) acc++;
        end
    endtask

    // Slot at r=16 was empty; the next sample goes in at r=20.
    task automatic test_idle_slot();
        for (int r = 17; r <= 23; r++) begin
            @(negedge ph1);
            smp_valid = (r == 20);
            smp_data  = 8'd9;
            #1;
            checks++;
            if (smp_ready !== (r % 4 == 0) || data_clk_en !== (r == 21)) begin
                errors++;
                $display("FAIL idle_slot r=%0d: got smp_ready=%b dce=%b required %b %b",
                         r, smp_ready, data_clk_en, (r % 4 == 0), (r == 21));
            end
            checks++;
            if (a !== ((r <= 20) ? 8'd4 : 8'd9)) begin
                errors++;
                $display("FAIL idle_slot_a r=%0d: got %0d required %0d", r, a, (r <= 20) ? 4 : 9);
            end
            checks++;
            if (y_valid !== (r == 23)) begin
                errors++;
                $display("FAIL idle_y_valid r=%0d: got %b required %b", r, y_valid, (r == 23));
            end
            if (r == 23) begin
                checks++;
                if (y_dp !== 18'd34) begin
                    errors++;
                    $display("FAIL idle_y: got %0d required 34", y_dp);
                end
            end
        end
    endtask

    task automatic test_collision();
        @(negedge ph1);
        cfg_coef  = 32'h01010101;
        cfg_valid = 1'b1;
        smp_valid = 1'b1;
        smp_data  = 8'd77;
        #1;
        checks++;
        if (smp_ready !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL collision: got smp_ready=%b cfg_ready=%b required 0 1", smp_ready, cfg_ready);
        end
        test_load(32'h01010101);
        test_fill(18'd10);
    endtask

    task automatic test_reset_mid_load();
        @(negedge ph1);
        cfg_coef  = 32'hA5A5A5A5;
        cfg_valid = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL midload_cfg_ready: got %b required 1", cfg_ready);
        end
        repeat (10) begin
            @(negedge ph1);
            cfg_valid = 1'b0;
        end
        @(negedge ph1);
        reset = 1'b0;
        #1;
        checks++;
        if ({cfg_ready, smp_ready, data_clk_en, shift_clk_en, shift_in, y_valid, busy, a} !== 15'd0) begin
            errors++;
            $display("FAIL midload_reset_outputs: got %b required all zero",
                     {cfg_ready, smp_ready, data_clk_en, shift_clk_en, shift_in, y_valid, busy, a});
        end
        @(negedge ph1);
        reset = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1 || smp_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midload_release: got cfg_ready=%b smp_ready=%b busy=%b required 1 0 0",
                     cfg_ready, smp_ready, busy);
        end
        @(negedge ph1);
        #1;
        checks++;
        if (shift_clk_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midload_no_resume: got sce=%b busy=%b required 0 0", shift_clk_en, busy);
        end
    endtask

`ifdef FIR_CTRL_PERF_EN
    task automatic test_perf();
        logic [6:0] pat;
        pat = 7'b1101011;
        @(negedge ph1);
        cfg_coef  = 32'h04030201;
        cfg_valid = 1'b1;
        test_load(32'h04030201);
        for (int r = 0; r < 28; r++) begin
            @(negedge ph1);
            smp_valid = (r % 4 == 0) ? pat[r / 4] : 1'b0;
            smp_data  = 8'(r);
        end
        @(negedge ph1);
        cfg_valid = 1'b1;
        smp_valid = 1'b1;
        #1;
        checks++;
        if (smp_count !== 16'd5 || drop_count !== 16'd2 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL perf_counts: got smp=%0d drop=%0d cfg_ready=%b required 5 2 1",
                     smp_count, drop_count, cfg_ready);
        end
        @(negedge ph1);
        cfg_valid = 1'b0;
        smp_valid = 1'b0;
        #1;
        checks++;
        if (smp_count !== 16'd0 || drop_count !== 16'd2) begin
            errors++;
            $display("FAIL perf_cfg_clear: got smp=%0d drop=%0d required 0 2", smp_count, drop_count);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_coef();
        test_fill(18'd20);
        test_idle_slot();
        test_collision();
        test_reset_mid_load();
`ifdef FIR_CTRL_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
